core_ram_resp: RTL and testbench
================================

CORE_RAM_RESP -- requirements
Module: core_ram_resp

Interface
REQ-001 SHALL have parameter WFIFO_DEPTH, default 4, xdata write-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter XADDR_W, default 16, external xdata bus address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 data_rd_en  input  1  core internal-data read strobe, one cycle per request.
REQ-007 xdata_rd_en  input  1  core xdata read strobe, one cycle per request.
REQ-008 ram_rd_addr  input  16  read address; data space uses bits [7:0].
REQ-009 ram_rd_data  output  8  read data returned to core.
REQ-010 ram_rd_vld  output  1  one-cycle pulse qualifying ram_rd_data.
REQ-011 data_wr_en  input  1  core internal-data write strobe.
REQ-012 xdata_wr_en  input  1  core xdata write strobe.
REQ-013 ram_wr_addr  input  16  write address; data space uses bits [7:0].
REQ-014 ram_wr_data  input  8  write data.
REQ-015 xm_req  output  1  external xdata request, held until xm_ack.
REQ-016 xm_we  output  1  external request is write (1) or read (0); stable while xm_req.
REQ-017 xm_addr  output  XADDR_W  external address; stable while xm_req.
REQ-018 xm_wdata  output  8  external write data; stable while xm_req.
REQ-019 xm_ack  input  1  external completion pulse; ignored when xm_req=0.
REQ-020 xm_rdata  input  8  external read data, valid with xm_ack on reads.
REQ-021 proto_err  output  1  sticky protocol-error flag.

Function
REQ-022 Data space: 256x8 internal array; data_rd_en in cycle N -> ram_rd_vld=1 and ram_rd_data=array[addr] in cycle N+1.
REQ-023 Data write same cycle/address as data read: read returns pre-write value (read-first).
REQ-024 xdata writes: pushed into write FIFO in the strobe cycle; core never stalled.
REQ-025 FIFO drained in order, one xm transaction at a time, xm_we=1.
REQ-026 xdata read: queued as single pending read; issued (xm_we=0) only after FIFO empty and no write in flight (write-before-read ordering).
REQ-027 Read xm_ack in cycle M -> ram_rd_vld=1, ram_rd_data=xm_rdata in cycle M+1.
REQ-028 ram_rd_data SHALL hold last returned value between pulses.
REQ-029 Controller FSM states: IDLE, WR_BUSY (write on bus), RD_HOLD (read pending, FIFO draining), RD_BUSY (read on bus); IDLE->WR_BUSY on FIFO non-empty; WR_BUSY->IDLE/WR_BUSY/RD_BUSY on ack per FIFO/read state; IDLE->RD_BUSY on read with FIFO empty; RD_HOLD->RD_BUSY when FIFO empty and ack of last write; RD_BUSY->IDLE/WR_BUSY on ack.
REQ-030 xm_req deasserts the cycle after xm_ack; next request may assert the following cycle at earliest.
REQ-031 FIFO push while full: entry dropped, proto_err set.
REQ-032 Push and pop same cycle when full: push accepted.
REQ-033 data_rd_en and xdata_rd_en same cycle: data read served, xdata read dropped, proto_err set.
REQ-034 xdata_rd_en while xdata read pending or in flight: dropped, proto_err set.
REQ-035 Internal data read completing same cycle as xdata return: data vld in that cycle, xdata vld delayed one cycle (one-entry return slot).
REQ-036 FIFO pointers wrap modulo WFIFO_DEPTH; full/empty via extra pointer bit.

Reset
REQ-037 On rst: ram_rd_vld=0, ram_rd_data=0, xm_req=0, xm_we=0, xm_addr=0, xm_wdata=0, proto_err=0, FIFO empty, pending read cleared, FSM=IDLE.
REQ-038 rst mid-transaction abandons it; late xm_ack after reset SHALL be ignored.
REQ-039 Data-array contents unaffected by rst.

Structure
REQ-040 Shared package core_mem_pkg: FSM state enum, default WFIFO_DEPTH, XADDR_W.
REQ-041 Write buffer SHALL be sub-module core_ram_wfifo (synchronous FIFO, push/pop/full/empty).

Verification
REQ-042 data write 0x30<-0xA5, then data read 0x30 -> vld next cycle, data 0xA5.
REQ-043 xdata writes 0x1000<-0x11, 0x1001<-0x22 then read 0x1001, xm_ack delay 3 -> two writes on bus in order before read; vld with 0x22 one cycle after read ack.
REQ-044 Five back-to-back xdata writes, xm_ack withheld -> fifth dropped, proto_err=1, first four drain in order.
REQ-045 data_rd_en and xdata_rd_en asserted together -> one vld with data value, no xm_req read, proto_err=1.
REQ-046 rst during RD_BUSY, xm_ack 2 cycles later -> no ram_rd_vld, xm_req=0, FSM IDLE.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types and defaults for the core RAM response block and its write buffer.
package core_mem_pkg;

    localparam int WFIFO_DEPTH_DFLT = 4;
    localparam int XADDR_W_DFLT     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_HOLD = 2'd2,
        RD_BUSY = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

endpackage

// File: rtl/core_ram_wfifo.sv
// Synchronous FIFO buffering xdata writes; occupancy tracked with an extra pointer bit.
module core_ram_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         one
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] ONE_ENTRY = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count;
    logic         do_push;
    logic         do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one     = (count == ONE_ENTRY);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is left out of reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/core_ram_resp.sv
// Core RAM responder: internal 256x8 data space plus buffered, write-before-read xdata bus.
module core_ram_resp
    import core_mem_pkg::*;
#(
    parameter int WFIFO_DEPTH = WFIFO_DEPTH_DFLT,
    parameter int XADDR_W     = XADDR_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_rd_en,
    input  logic               xdata_rd_en,
    input  logic [15:0]        ram_rd_addr,
    output logic [7:0]         ram_rd_data,
    output logic               ram_rd_vld,
    input  logic               data_wr_en,
    input  logic               xdata_wr_en,
    input  logic [15:0]        ram_wr_addr,
    input  logic [7:0]         ram_wr_data,
    output logic               xm_req,
    output logic               xm_we,
    output logic [XADDR_W-1:0] xm_addr,
    output logic [7:0]         xm_wdata,
    input  logic               xm_ack,
    input  logic [7:0]         xm_rdata,
    output logic               proto_err
);
    ctrl_state_e state;
    logic [7:0]  dmem [256];
    wr_entry_t   fifo_wdata;
    wr_entry_t   fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_one;
    logic        fifo_pop;
    logic        rd_pend;
    logic [15:0] rd_addr;
    logic        slot_vld;
    logic [7:0]  slot_data;

    logic wr_on_bus, wr_ack, rd_ack, wr_issue, wr_left;
    logic rd_accept, rd_drop, rd_waiting, push_drop;

    assign fifo_wdata = '{addr: ram_wr_addr, data: ram_wr_data};
    assign wr_on_bus  = (state == WR_BUSY) || (state == RD_HOLD);
    assign wr_ack     = wr_on_bus && xm_req && xm_ack;
    assign rd_ack     = (state == RD_BUSY) && xm_req && xm_ack;
    // The in-flight write stays at the FIFO head until acked, so it counts against capacity.
    assign fifo_pop   = wr_ack;
    assign wr_issue   = !fifo_empty && ((state == IDLE) || (wr_on_bus && !xm_req));
    assign wr_left    = !fifo_one || xdata_wr_en;
    assign rd_accept  = xdata_rd_en && !data_rd_en && !rd_pend;
    assign rd_drop    = xdata_rd_en && (data_rd_en || rd_pend);
    assign rd_waiting = rd_pend || rd_accept;
    assign push_drop  = xdata_wr_en && fifo_full && !fifo_pop;

    core_ram_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     ($bits(wr_entry_t))
    ) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xdata_wr_en),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .one   (fifo_one)
    );

    always_ff @(posedge clk) begin
        if (data_wr_en) dmem[ram_wr_addr[7:0]] <= ram_wr_data;
    end

    // Acks are only honoured while xm_req is high, which also discards acks arriving after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            xm_req   <= 1'b0;
            xm_we    <= 1'b0;
            xm_addr  <= '0;
            xm_wdata <= '0;
            rd_pend  <= 1'b0;
            rd_addr  <= '0;
        end else begin
            if (rd_accept) begin
                rd_pend <= 1'b1;
                rd_addr <= ram_rd_addr;
            end
            if (rd_ack) rd_pend <= 1'b0;
            if (wr_issue) begin
                xm_req   <= 1'b1;
                xm_we    <= 1'b1;
                xm_addr  <= XADDR_W'(fifo_head.addr);
                xm_wdata <= fifo_head.data;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= rd_accept ? RD_HOLD : WR_BUSY;
                    end else if (rd_accept) begin
                        xm_req  <= 1'b1;
                        xm_we   <= 1'b0;
                        xm_addr <= XADDR_W'(ram_rd_addr);
                        state   <= RD_BUSY;
                    end
                end
                WR_BUSY, RD_HOLD: begin
                    if (rd_waiting) state <= RD_HOLD;
                    if (wr_ack) begin
                        xm_req <= 1'b0;
                        if (wr_left) state <= rd_waiting ? RD_HOLD : WR_BUSY;
                        else         state <= rd_waiting ? RD_BUSY : IDLE;
                    end
                end
                RD_BUSY: begin
                    if (!xm_req) begin
                        xm_req  <= 1'b1;
                        xm_we   <= 1'b0;
                        xm_addr <= XADDR_W'(rd_addr);
                    end else if (xm_ack) begin
                        xm_req <= 1'b0;
                        state  <= fifo_empty ? IDLE : WR_BUSY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Internal reads win the return port; a colliding xdata return waits one cycle in the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_vld  <= 1'b0;
            ram_rd_data <= '0;
            slot_vld    <= 1'b0;
            slot_data   <= '0;
        end else begin
            ram_rd_vld <= 1'b0;
            if (data_rd_en) begin
                ram_rd_vld  <= 1'b1;
                ram_rd_data <= dmem[ram_rd_addr[7:0]];
                if (rd_ack) begin
                    slot_vld  <= 1'b1;
                    slot_data <= xm_rdata;
                end
            end else if (slot_vld) begin
                ram_rd_vld  <= 1'b1;
                ram_rd_data <= slot_data;
                slot_vld    <= 1'b0;
            end else if (rd_ack) begin
                ram_rd_vld  <= 1'b1;
                ram_rd_data <= xm_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         proto_err <= 1'b0;
        else if (push_drop || rd_drop)   proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_core_ram_resp.sv
// Directed bench for core_ram_resp with a small external xdata memory responder.
module tb_core_ram_resp;
    import core_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_rd_en, xdata_rd_en, data_wr_en, xdata_wr_en;
    logic [15:0] ram_rd_addr, ram_wr_addr;
    logic [7:0]  ram_wr_data, ram_rd_data;
    logic        ram_rd_vld;
    logic        xm_req, xm_we, xm_ack, proto_err;
    logic [15:0] xm_addr;
    logic [7:0]  xm_wdata, xm_rdata;

    logic        resp_ack, man_ack;
    logic        ack_en;
    int          ack_dly;
    int          cnt;
    int          cyc = 0;
    int          rd_ack_cyc = -100;
    int          gap_err = 0;
    logic [24:0] log_q [$];
    logic [7:0]  xmem [logic [15:0]];

    int n_checks = 0;
    int n_fail   = 0;

    assign xm_ack = resp_ack | man_ack;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_ram_resp dut (
        .clk         (clk),
        .rst         (rst),
        .data_rd_en  (data_rd_en),
        .xdata_rd_en (xdata_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_rd_vld  (ram_rd_vld),
        .data_wr_en  (data_wr_en),
        .xdata_wr_en (xdata_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .xm_req      (xm_req),
        .xm_we       (xm_we),
        .xm_addr     (xm_addr),
        .xm_wdata    (xm_wdata),
        .xm_ack      (xm_ack),
        .xm_rdata    (xm_rdata),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        data_rd_en  = 1'b0;
        xdata_rd_en = 1'b0;
        data_wr_en  = 1'b0;
        xdata_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // External memory: acks after ack_dly cycles of xm_req and logs each completed transaction.
    initial begin
        resp_ack = 1'b0;
        xm_rdata = 8'h00;
        cnt      = 0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_ack && xm_req) gap_err++;
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt      = 0;
            end else if (xm_req && ack_en) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    resp_ack = 1'b1;
                    log_q.push_back({xm_we, xm_addr, xm_wdata});
                    if (xm_we) begin
                        xmem[xm_addr] = xm_wdata;
                    end else begin
                        xm_rdata   = xmem.exists(xm_addr) ? xmem[xm_addr] : 8'h00;
                        rd_ack_cyc = cyc;
                    end
                end
            end else if (!xm_req) begin
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, vld_cyc, n_vld, n_req;
        logic [7:0] vld_data;

        rst = 1'b1; man_ack = 1'b0; ack_en = 1'b0; ack_dly = 1;
        clear_in();
        ram_rd_addr = '0; ram_wr_addr = '0; ram_wr_data = '0;
        tick();
        tick();
        check("rst_vld",      ram_rd_vld, 0);
        check("rst_rdata",    ram_rd_data, 0);
        check("rst_req",      xm_req, 0);
        check("rst_we",       xm_we, 0);
        check("rst_addr",     xm_addr, 0);
        check("rst_wdata",    xm_wdata, 0);
        check("rst_err",      proto_err, 0);
        check("rst_state",    dut.state, IDLE);
        rst = 1'b0;

        // Internal data space: write then read, hold, read-first collision
        data_wr_en = 1'b1; ram_wr_addr = 16'h0030; ram_wr_data = 8'hA5;
        tick();
        data_wr_en = 1'b0; data_rd_en = 1'b1; ram_rd_addr = 16'h0030;
        tick();
        check("drd_vld",  ram_rd_vld, 1);
        check("drd_data", ram_rd_data, 8'hA5);
        data_rd_en = 1'b0;
        tick();
        check("drd_vld_pulse", ram_rd_vld, 0);
        check("drd_hold",      ram_rd_data, 8'hA5);
        data_wr_en = 1'b1; ram_wr_data = 8'h3C; data_rd_en = 1'b1;
        tick();
        check("rdfirst_old", ram_rd_data, 8'hA5);
        data_wr_en = 1'b0;
        tick();
        check("rdfirst_new", ram_rd_data, 8'h3C);
        data_rd_en = 1'b0;
        check("drd_no_bus",  xm_req, 0);

        // Two xdata writes then read of the second address, ack delay 3
        log_q.delete(); ack_en = 1'b1; ack_dly = 3;
        xdata_wr_en = 1'b1; ram_wr_addr = 16'h1000; ram_wr_data = 8'h11;
        tick();
        ram_wr_addr = 16'h1001; ram_wr_data = 8'h22;
        tick();
        xdata_wr_en = 1'b0; xdata_rd_en = 1'b1; ram_rd_addr = 16'h1001;
        tick();
        xdata_rd_en = 1'b0;
        got = 0; vld_cyc = 0; vld_data = '0;
        for (int i = 0; i < 80 && got == 0; i++) begin
            if (ram_rd_vld) begin
                got = 1; vld_cyc = cyc; vld_data = ram_rd_data;
            end else begin
                tick();
            end
        end
        check("xrd_vld",  got, 1);
        check("xrd_data", vld_data, 8'h22);
        check("xrd_lat",  vld_cyc - rd_ack_cyc, 1);
        check("xlog_n",   log_q.size(), 3);
        check("xlog_wr0", log_q[0], {1'b1, 16'h1000, 8'h11});
        check("xlog_wr1", log_q[1], {1'b1, 16'h1001, 8'h22});
        check("xlog_rd",  log_q[2], {1'b0, 16'h1001, 8'h22});
        tick();
        check("xrd_pulse", ram_rd_vld, 0);

        // Five back-to-back writes with ack withheld: fifth dropped
        log_q.delete(); ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            xdata_wr_en = 1'b1;
            ram_wr_addr = 16'h2000 + 16'(i);
            ram_wr_data = 8'h40 + 8'(i);
            tick();
        end
        xdata_wr_en = 1'b0;
        check("ovf_err",  proto_err, 1);
        check("ovf_req",  xm_req, 1);
        check("ovf_addr", xm_addr, 16'h2000);
        ack_en = 1'b1; ack_dly = 1;
        for (int i = 0; i < 100 && log_q.size() < 4; i++) tick();
        for (int i = 0; i < 8; i++) tick();
        check("ovf_n", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ea;
            logic [7:0]  ed;
            ea = 16'h2000 + 16'(i);
            ed = 8'h40 + 8'(i);
            check($sformatf("ovf_wr%0d", i), log_q[i], {1'b1, ea, ed});
        end
        check("ovf_idle_req", xm_req, 0);
        check("ovf_state",    dut.state, IDLE);

        // Simultaneous data and xdata read; data array survives reset
        do_reset();
        check("rst2_err", proto_err, 0);
        log_q.delete();
        data_rd_en = 1'b1; xdata_rd_en = 1'b1; ram_rd_addr = 16'h0030;
        tick();
        clear_in();
        check("both_vld",  ram_rd_vld, 1);
        check("both_data", ram_rd_data, 8'h3C);
        n_vld = 0; n_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vld += int'(ram_rd_vld);
            n_req += int'(xm_req);
        end
        check("both_extra_vld", n_vld, 0);
        check("both_no_req",    n_req, 0);
        check("both_err",       proto_err, 1);
        check("both_no_log",    log_q.size(), 0);

        // Second read while one in flight; data read colliding with xdata return
        do_reset();
        ack_dly = 3;
        xdata_rd_en = 1'b1; ram_rd_addr = 16'h1000;
        tick();
        check("inf_state", dut.state, RD_BUSY);
        check("inf_we",    xm_we, 0);
        ram_rd_addr = 16'h1001;
        tick();
        xdata_rd_en = 1'b0;
        check("inf_drop_err", proto_err, 1);
        tick();
        data_rd_en = 1'b1; ram_rd_addr = 16'h0030;
        tick();
        data_rd_en = 1'b0;
        check("coll_dvld",  ram_rd_vld, 1);
        check("coll_ddata", ram_rd_data, 8'h3C);
        tick();
        check("coll_xvld",  ram_rd_vld, 1);
        check("coll_xdata", ram_rd_data, 8'h11);
        tick();
        check("coll_end",   ram_rd_vld, 0);
        check("coll_addr",  xm_addr, 16'h1000);

        // Reset during RD_BUSY, late ack ignored
        do_reset();
        ack_en = 1'b0;
        xdata_rd_en = 1'b1; ram_rd_addr = 16'h1000;
        tick();
        xdata_rd_en = 1'b0;
        check("abort_busy", dut.state, RD_BUSY);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_req", xm_req, 0);
        n_vld = 0;
        tick();
        n_vld += int'(ram_rd_vld);
        man_ack = 1'b1;
        tick();
        n_vld += int'(ram_rd_vld);
        man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vld += int'(ram_rd_vld);
        end
        check("abort_no_vld", n_vld, 0);
        check("abort_req2",   xm_req, 0);
        check("abort_state",  dut.state, IDLE);
        check("abort_rdata",  ram_rd_data, 0);

        check("req_gap", gap_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
